// File: rtl/spine_link_egress.sv
// spine_link_egress: spine-end receiver for one leaf-router spine output.
// Flits arrive with no backpressure. They are buffered in a FIFO and then
// relaunched from a single output register on a valid/ready link. Overflow
// drops and sustained downstream stalls are tracked by counters and sticky flags.
module spine_link_egress #(
    parameter int DWIDTH      = 16,
    parameter int DEPTH       = 8,
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [DWIDTH-1:0]            rx_data,
    input  logic                         rx_valid,
    output logic [DWIDTH-1:0]            tx_data,
    output logic                         tx_valid,
    output logic [5:0]                   tx_dest_addr,
    input  logic                         tx_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [CNT_W-1:0]             drop_count,
    output logic                         overflow_err,
    output logic                         stall_err,
    input  logic                         clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(STALL_LIMIT+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] STALL_C = SW'(STALL_LIMIT);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [SW-1:0]     stall_cnt;

    logic              out_load, pop, bypass, wr, drop, stalling;
    logic [CW-1:0]     count_nxt;
    logic [DWIDTH-1:0] src;

    // Handshake decode: output register reload, FIFO pop/write, bypass and drop.
    always_comb begin
        out_load  = !tx_valid || tx_ready;
        pop       = out_load && !fifo_empty;
        bypass    = out_load && fifo_empty && rx_valid;
        wr        = rx_valid && !bypass && ((fifo_count != DEPTH_C) || pop);
        drop      = rx_valid && !bypass && !wr;
        stalling  = tx_valid && !tx_ready;
        src       = pop ? mem[rd_ptr] : rx_data;
        count_nxt = fifo_count;
        if (wr && !pop)
            count_nxt = fifo_count + 1'b1;
        else if (pop && !wr)
            count_nxt = fifo_count - 1'b1;
    end

    // FIFO storage; holds only data, so it needs no reset.
    always_ff @(posedge ACLK) begin
        if (wr)
            mem[wr_ptr] <= rx_data;
    end

    // FIFO pointers and registered occupancy flags, all updated together.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_nxt;
            fifo_full  <= (count_nxt == DEPTH_C);
            fifo_empty <= (count_nxt == '0);
        end
    end

    // Output register: data and destination are always loaded from the same flit.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tx_valid     <= 1'b0;
            tx_data      <= '0;
            tx_dest_addr <= '0;
        end else if (out_load) begin
            tx_valid <= pop || bypass;
            if (pop || bypass) begin
                tx_data      <= src;
                tx_dest_addr <= src[DWIDTH-1 -: 6];
            end
        end
    end

    // Drop accounting: saturating counter plus sticky flag; a clear wins.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            drop_count   <= '0;
            overflow_err <= 1'b0;
        end else if (clr_err) begin
            drop_count   <= '0;
            overflow_err <= 1'b0;
        end else if (drop) begin
            if (drop_count != '1)
                drop_count <= drop_count + 1'b1;
            overflow_err <= 1'b1;
        end
    end

    // Stall watchdog: counts consecutive stalled cycles and holds at the limit.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (clr_err) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (stalling) begin
            if (stall_cnt != STALL_C)
                stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= STALL_C - 1'b1)
                stall_err <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule
